// File: rtl/rf_pkg.sv
// Shared definitions for the 16x16 register file access path.
//   RF_NUM_REGS / RF_AW / RF_DW : register count, address and data widths
//   rf_addr_t                   : register address type
//   rf_wr_t                     : registered write-stage contents
//   rf_onehot()                 : address to one-hot register select
package rf_pkg;
  localparam int RF_NUM_REGS = 16;
  localparam int RF_AW       = 4;
  localparam int RF_DW       = 16;

  typedef logic [RF_AW-1:0] rf_addr_t;

  typedef struct packed {
    logic             vld;
    rf_addr_t         addr;
    logic [RF_DW-1:0] data;
  } rf_wr_t;

  function automatic logic [RF_NUM_REGS-1:0] rf_onehot(input rf_addr_t addr);
    rf_onehot       = '0;
    rf_onehot[addr] = 1'b1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req     : request vector
//   rr_ptr  : index of the last granted requester; scan starts one past it
//   stall   : suppresses all grants
//   gnt     : one-hot grant (all zero when stalled or idle)
//   gnt_idx : encoded index of the granted requester (0 when idle)
module rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] rr_ptr,
  input  logic          stall,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx
);
  always_comb begin
    int idx;
    gnt     = '0;
    gnt_idx = '0;
    idx     = 0;
    if (!stall) begin
      for (int k = 1; k <= N; k++) begin
        idx = (int'(rr_ptr) + k) % N;
        if (gnt == '0 && req[idx]) begin
          gnt[idx] = 1'b1;
          gnt_idx  = PW'(idx);
        end
      end
    end
  end
endmodule

// File: rtl/rf_port_ctrl.sv
// Register file access controller.
// Round-robin arbitrates NUM_REQ write requesters onto the single write path,
// registers the winner, and drives one-hot write enables plus the data bus one
// cycle after the grant. Decodes two read addresses into one-hot read enables.
// Ports:
//   clk, rst              : clock, async active-high reset
//   req/req_addr/req_data : packed write requests (requester i at [i*W +: W])
//   gnt                   : one-hot combinational grant
//   wr_stall              : blocks new grants
//   write_reg, d          : register file write enables and data
//   rd_addr1/2, rd_en1/2  : read port addresses and enables
//   rden1/2               : one-hot read enables
//   busy                  : write stage holds a valid write
// Optional macro RF_BYPASS_EN adds byp1/2_vld and byp1/2_data: a read of the
// register being written this cycle is served from the write stage instead of
// the bitlines.
module rf_port_ctrl
  import rf_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int AW       = RF_AW,
  parameter int DW       = RF_DW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ*AW-1:0] req_addr,
  input  logic [NUM_REQ*DW-1:0] req_data,
  output logic [NUM_REQ-1:0]    gnt,
  input  logic                  wr_stall,
  output logic [NUM_REGS-1:0]   write_reg,
  output logic [DW-1:0]         d,
  input  logic [AW-1:0]         rd_addr1,
  input  logic [AW-1:0]         rd_addr2,
  input  logic                  rd_en1,
  input  logic                  rd_en2,
  output logic [NUM_REGS-1:0]   rden1,
  output logic [NUM_REGS-1:0]   rden2,
`ifdef RF_BYPASS_EN
  output logic                  byp1_vld,
  output logic                  byp2_vld,
  output logic [DW-1:0]         byp1_data,
  output logic [DW-1:0]         byp2_data,
`endif
  output logic                  busy
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] gnt_idx;
  rf_wr_t        wr_q;

  // Reset also gates the arbiter so gnt reads zero while rst is held.
  rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_arb (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .stall   (wr_stall | rst),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Write stage: capture the granted requester's fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q   <= '0;
      rr_ptr <= PW'(NUM_REQ - 1);
    end else begin
      wr_q.vld <= |gnt;
      if (|gnt) begin
        wr_q.addr <= req_addr[gnt_idx*AW +: AW];
        wr_q.data <= req_data[gnt_idx*DW +: DW];
        rr_ptr    <= gnt_idx;
      end
    end
  end

  assign write_reg = wr_q.vld ? rf_onehot(wr_q.addr) : '0;
  assign d         = wr_q.data;
  assign busy      = wr_q.vld;

  // Read decode. With bypass, a read hitting the in-flight write skips the
  // bitlines and takes the write-stage data.
  logic hit1, hit2;
`ifdef RF_BYPASS_EN
  assign hit1      = rd_en1 && wr_q.vld && (rd_addr1 == wr_q.addr);
  assign hit2      = rd_en2 && wr_q.vld && (rd_addr2 == wr_q.addr);
  assign byp1_vld  = hit1;
  assign byp2_vld  = hit2;
  assign byp1_data = hit1 ? wr_q.data : '0;
  assign byp2_data = hit2 ? wr_q.data : '0;
`else
  assign hit1 = 1'b0;
  assign hit2 = 1'b0;
`endif

  assign rden1 = (rd_en1 && !hit1) ? rf_onehot(rd_addr1) : '0;
  assign rden2 = (rd_en2 && !hit2) ? rf_onehot(rd_addr2) : '0;
endmodule

// File: tb/tb_rf_port_ctrl.sv
module tb_rf_port_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [7:0]  req_addr;
  logic [31:0] req_data;
  logic [1:0]  gnt;
  logic        wr_stall;
  logic [15:0] write_reg;
  logic [15:0] d;
  logic [3:0]  rd_addr1, rd_addr2;
  logic        rd_en1, rd_en2;
  logic [15:0] rden1, rden2;
  logic        busy;
`ifdef RF_BYPASS_EN
  logic        byp1_vld, byp2_vld;
  logic [15:0] byp1_data, byp2_data;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rf_port_ctrl dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
    .gnt(gnt), .wr_stall(wr_stall), .write_reg(write_reg), .d(d),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_en1(rd_en1), .rd_en2(rd_en2),
    .rden1(rden1), .rden2(rden2),
`ifdef RF_BYPASS_EN
    .byp1_vld(byp1_vld), .byp2_vld(byp2_vld),
    .byp1_data(byp1_data), .byp2_data(byp2_data),
`endif
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; leave time after the edge for inputs and outputs to settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [3:0] a, input logic [15:0] dat);
    req_addr[i*4 +: 4]   = a;
    req_data[i*16 +: 16] = dat;
  endtask

  initial begin
    rst = 1'b1; req = '0; req_addr = '0; req_data = '0; wr_stall = 1'b0;
    rd_addr1 = '0; rd_addr2 = '0; rd_en1 = 1'b0; rd_en2 = 1'b0;
    #12;
    chk("rst_write_reg", 32'(write_reg), 32'h0);
    chk("rst_busy",      32'(busy),      32'h0);
    chk("rst_d",         32'(d),         32'h0);
    chk("rst_gnt",       32'(gnt),       32'h0);
    rst = 1'b0;
    tick();

    // Single write from requester 1
    req = 2'b10; set_req(1, 4'd5, 16'hBEEF);
    #1 chk("single_gnt", 32'(gnt), 32'h2);
    tick();
    req = 2'b00;
    #1;
    chk("single_we",   32'(write_reg), 32'h0020);
    chk("single_d",    32'(d),         32'hBEEF);
    chk("single_busy", 32'(busy),      32'h1);
    tick();
    chk("single_done", 32'(write_reg), 32'h0);
    chk("single_idle", 32'(busy),      32'h0);

    // Round-robin: both requesting; winner presents its next request
    req = 2'b11; set_req(0, 4'd1, 16'h1111); set_req(1, 4'd2, 16'h2222);
    #1 chk("rr_gnt0", 32'(gnt), 32'h1);
    tick();
    set_req(0, 4'd3, 16'h3333);
    #1;
    chk("rr_we0",   32'(write_reg), 32'h0002);
    chk("rr_d0",    32'(d),         32'h1111);
    chk("rr_gnt1",  32'(gnt),       32'h2);
    tick();
    set_req(1, 4'd4, 16'h4444);
    #1;
    chk("rr_we1",   32'(write_reg), 32'h0004);
    chk("rr_d1",    32'(d),         32'h2222);
    chk("rr_gnt2",  32'(gnt),       32'h1);
    tick();
    #1;
    chk("rr_we2",   32'(write_reg), 32'h0008);
    chk("rr_d2",    32'(d),         32'h3333);
    chk("rr_gnt3",  32'(gnt),       32'h2);
    tick();
    req = 2'b00;
    #1;
    chk("rr_we3",   32'(write_reg), 32'h0010);
    chk("rr_d3",    32'(d),         32'h4444);
    tick();

    // Stall: a registered write completes while new grants are blocked
    req = 2'b10; set_req(1, 4'd6, 16'h6666);
    #1 chk("stall_pre_gnt", 32'(gnt), 32'h2);
    tick();
    req = 2'b01; set_req(0, 4'd9, 16'h9999); wr_stall = 1'b1;
    #1;
    chk("stall_gnt_a",  32'(gnt),       32'h0);
    chk("stall_we",     32'(write_reg), 32'h0040);
    chk("stall_d",      32'(d),         32'h6666);
    tick();
    chk("stall_gnt_b",  32'(gnt),       32'h0);
    chk("stall_busy_b", 32'(busy),      32'h0);
    tick();
    chk("stall_gnt_c",  32'(gnt),       32'h0);
    tick();
    wr_stall = 1'b0;
    #1 chk("stall_release_gnt", 32'(gnt), 32'h1);
    tick();
    req = 2'b00;
    #1;
    chk("stall_post_we", 32'(write_reg), 32'h0200);
    chk("stall_post_d",  32'(d),         32'h9999);
    tick();

    // Read decode
    rd_addr1 = 4'd0; rd_addr2 = 4'd15; rd_en1 = 1'b1; rd_en2 = 1'b1;
    #1;
    chk("rd1_r0",  32'(rden1), 32'h0001);
    chk("rd2_r15", 32'(rden2), 32'h8000);
    rd_en2 = 1'b0;
    #1 chk("rd2_off", 32'(rden2), 32'h0);
    rd_addr2 = 4'd0; rd_en2 = 1'b1;
    #1 chk("rd2_same", 32'(rden2), 32'h0001);
    rd_en1 = 1'b0; rd_en2 = 1'b0;

    // Read of a register in its write cycle
    req = 2'b01; set_req(0, 4'd3, 16'h1234);
    tick();
    req = 2'b00; rd_addr1 = 4'd3; rd_en1 = 1'b1; rd_addr2 = 4'd4; rd_en2 = 1'b1;
    #1;
    chk("byp_we", 32'(write_reg), 32'h0008);
`ifdef RF_BYPASS_EN
    chk("byp_rden1",  32'(rden1),     32'h0);
    chk("byp1_vld",   32'(byp1_vld),  32'h1);
    chk("byp1_data",  32'(byp1_data), 32'h1234);
    chk("byp2_vld",   32'(byp2_vld),  32'h0);
    chk("byp2_data",  32'(byp2_data), 32'h0);
`else
    chk("nobyp_rden1", 32'(rden1), 32'h0008);
`endif
    chk("byp_rden2", 32'(rden2), 32'h0010);
    rd_en1 = 1'b0; rd_en2 = 1'b0;
    tick();

    // Reset mid-write: last grant came from requester 0, so without pointer
    // restore requester 1 would win next.
    req = 2'b11; set_req(0, 4'd7, 16'h7777); set_req(1, 4'd8, 16'h8888);
    req = 2'b01;
    tick();
    #1 chk("mid_busy", 32'(busy), 32'h1);
    req = 2'b11;
    #1 chk("mid_gnt_pre", 32'(gnt), 32'h2);
    rst = 1'b1;
    #1;
    chk("mid_rst_we",   32'(write_reg), 32'h0);
    chk("mid_rst_busy", 32'(busy),      32'h0);
    chk("mid_rst_gnt",  32'(gnt),       32'h0);
    rst = 1'b0;
    #1 chk("post_rst_gnt", 32'(gnt), 32'h1);
    tick();
    req = 2'b00;
    #1 chk("post_rst_we", 32'(write_reg), 32'h0080);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rf_port_ctrl.md
Name: rf_port_ctrl

Overview:
- Access controller for the 16x16 register file.
- Arbitrates NUM_REQ write requesters (e.g. ALU writeback, load unit) onto the file's single write path, round-robin.
- Registers the winning write, then drives the one-hot per-register write enables and the shared data bus.
- Decodes the two read addresses into one-hot per-register read enables for the two bitline ports.

Parameters:
- NUM_REQ, 2, number of write requesters (2..4).
- NUM_REGS, 16, number of registers; fixes the one-hot width.
- AW, 4, register address width (log2 NUM_REGS).
- DW, 16, data width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester write request.
- req_addr  in  NUM_REQ*AW  packed destination addresses; requester i at [i*AW +: AW].
- req_data  in  NUM_REQ*DW  packed write data; requester i at [i*DW +: DW].
- gnt  out  NUM_REQ  one-hot grant, combinational, same cycle as req.
- wr_stall  in  1  blocks all grants while high.
- write_reg  out  NUM_REGS  one-hot write enable to the register file.
- d  out  DW  write data to the register file.
- rd_addr1, rd_addr2  in  AW  read addresses.
- rd_en1, rd_en2  in  1  read port enables.
- rden1, rden2  out  NUM_REGS  one-hot read enables.
- busy  out  1  write stage holds a valid write.

Behaviour:
- Reset (asynchronous, active-high):
  - wr_vld_q=0, wr_addr_q=0, wr_data_q=0.
  - rr_ptr=NUM_REQ-1, so requester 0 has highest priority after reset.
  - Outputs: write_reg=0, d=0, busy=0, gnt=0.
- Arbitration, combinational:
  - If wr_stall=0, scan requesters starting at rr_ptr+1 (mod NUM_REQ).
  - The first asserted req gets gnt[i]=1. At most one gnt bit is high.
  - If wr_stall=1, or no req is asserted, gnt=0.
- Handshake:
  - A requester holds req, addr and data stable until it sees gnt high at a rising edge.
  - It may deassert req, or present a new request, in the following cycle.
- Write stage, registered at posedge:
  - wr_vld_q <= |gnt; wr_addr_q/wr_data_q <= the granted requester's fields; rr_ptr <= granted index.
  - With no grant: wr_vld_q <= 0 and rr_ptr is unchanged.
- Write outputs:
  - write_reg = wr_vld_q ? onehot(wr_addr_q) : 0.
  - d = wr_data_q; busy = wr_vld_q.
- Latency: grant in cycle N; write enables asserted in cycle N+1; the register file captures at the edge ending cycle N+1.
- Throughput: one write per cycle sustained.
- Fairness: with all requesters continuously asserted, grants rotate 0,1,...,NUM_REQ-1,0,...
- Same-address writes on consecutive cycles are both performed in grant order; the last write wins.
- Read decode, combinational:
  - rden1 = rd_en1 ? onehot(rd_addr1) : 0.
  - rden2 = rd_en2 ? onehot(rd_addr2) : 0.
  - Both ports may select the same register.
- Reset asserted mid-operation: the pending write is dropped (write_reg=0 immediately) and rr_ptr is restored.
- wr_stall asserted while wr_vld_q=1: the already-registered write still completes; only new grants are blocked.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined: adds outputs byp1_vld, byp2_vld (1 bit) and byp1_data, byp2_data (DW).
  - When rd_enX && wr_vld_q && rd_addrX==wr_addr_q: rdenX=0, bypX_vld=1, bypX_data=wr_data_q.
  - Otherwise bypX_vld=0 and bypX_data=0.
- Undefined: no bypass ports. Reads of a register in its write cycle return the pre-write value.

Decomposition:
- Shared package rf_pkg holds:
  - constants RF_NUM_REGS=16, RF_AW=4, RF_DW=16;
  - typedef rf_addr_t;
  - function rf_onehot(addr) returning a NUM_REGS-bit vector.
- One sub-module, rr_arbiter (parameter N): req, rr_ptr, stall in; one-hot gnt and encoded index out.
- Decode and write-stage logic stay in rf_port_ctrl.

Test Plan:
- Reset: rst=1 mid-write (wr_vld_q=1) -> write_reg=0, busy=0, gnt=0 immediately. After release, req=2'b11 -> gnt=2'b01.
- Single write: req[1]=1, addr=5, data=16'hBEEF in cycle N -> gnt=2'b10 in N; in N+1 write_reg=16'h0020, d=16'hBEEF, busy=1; in N+2 write_reg=0.
- Round-robin: req=2'b11 held for 4 cycles, distinct addresses -> gnt sequence 01,10,01,10; four writes performed in that order.
- Stall: req=2'b01 with wr_stall=1 for 3 cycles -> gnt=0 throughout; grant in the first cycle after wr_stall falls; registered write completes during the stall.
- Read decode: rd_addr1=0, rd_addr2=15, both enabled -> rden1=16'h0001, rden2=16'h8000. With rd_en2=0 -> rden2=0.
- Bypass (RF_BYPASS_EN): write of 16'h1234 to R3 in its write cycle, rd_addr1=3 -> rden1=0, byp1_vld=1, byp1_data=16'h1234. Without the macro -> rden1=16'h0008.
